noc_arbiter: RTL and testbench
==============================

# noc_arbiter

Shares a single NoC ingress link between `CPU_NB` cpu instances and steers the single NoC egress link back to them. Sits between the cpu array and the NoC. Upstream: round-robin arbitration of cpu->noc valid/ready requests into one registered output stage, tagged with the source index. Downstream: routing of noc->cpu beats to the addressed cpu, zero latency, with a sticky error for bad destinations.

## Interface
- `CPU_NB`, default 4: number of cpu requesters, range 2..16.
- `DATA_W`, default 64: payload width.
- `SRC_W`, default `$clog2(CPU_NB)`: source/destination tag width, derived locally, not overridden.
- `clk` in 1: single clock, all state on posedge.
- `rst_n` in 1: asynchronous, active-low reset. Assertion is immediate; deassertion is synchronous to `clk`.
- `cpu_to_noc_vld` in [CPU_NB]: per-cpu request valid.
- `cpu_to_noc_rdy` out [CPU_NB]: per-cpu accept, one-hot or zero.
- `cpu_to_noc_data` in [CPU_NB][DATA_W]: per-cpu payload.
- `noc_out_vld` out 1: registered beat valid toward the NoC.
- `noc_out_rdy` in 1: NoC accepts the beat.
- `noc_out_data` out DATA_W: registered payload.
- `noc_out_src` out SRC_W: index of the originating cpu.
- `noc_in_vld` in 1: NoC return beat valid.
- `noc_in_rdy` out 1: return beat accepted.
- `noc_in_data` in DATA_W: return payload.
- `noc_in_dst` in 32: destination cpu index, same encoding as `cpu_index`.
- `noc_to_cpu_vld` out [CPU_NB]: per-cpu return valid.
- `noc_to_cpu_rdy` in [CPU_NB]: per-cpu return ready.
- `noc_to_cpu_data` out [CPU_NB][DATA_W]: return payload, broadcast to all cpus.
- `err_bad_dst` out 1: sticky flag, set when a beat with `noc_in_dst >= CPU_NB` is accepted.

## Operation
- Output stage is a one-entry register holding `out_vld`, `out_data` and `out_src`.
- `load_ok = !noc_out_vld || noc_out_rdy`.
- Grant `g` is the first index `i` with `cpu_to_noc_vld[i]=1`, searching from `rr_ptr` upward modulo `CPU_NB`.
- `cpu_to_noc_rdy[i] = load_ok && any_vld && (i==g)`. This path is combinational from the vld inputs.
- When a grant is taken, on the next edge: `out_data <= cpu_to_noc_data[g]`, `out_src <= g`, `out_vld <= 1`, `rr_ptr <= (g==CPU_NB-1) ? 0 : g+1`.
- When `noc_out_rdy` is high and no grant is taken, `out_vld <= 0`. `rr_ptr` holds.
- `rr_ptr` advances only on an actual transfer, never on a stall.
- Downstream valid: `noc_to_cpu_vld[i] = noc_in_vld && (noc_in_dst==i)`.
- Downstream data: `noc_to_cpu_data[i] = noc_in_data` for every `i`.
- Downstream ready: `noc_in_rdy = noc_to_cpu_rdy[noc_in_dst]` when `noc_in_dst < CPU_NB`, otherwise 1. An out-of-range beat is drained and dropped.
- `err_bad_dst` is set on any drained out-of-range beat. It is cleared only by reset.

## Timing
- Reset values: `noc_out_vld=0`, `noc_out_data=0`, `noc_out_src=0`, `rr_ptr=0`, `err_bad_dst=0`.
- During reset, `cpu_to_noc_rdy=0`. The downstream path stays combinational.
- Upstream latency: a beat accepted at edge N appears on `noc_out_*` after edge N. Sustained throughput is 1 beat/cycle when `noc_out_rdy=1`.
- The output register holds stable while `noc_out_vld && !noc_out_rdy`. No cpu is granted in that state.
- Simultaneous drain and load in the same cycle gives back-to-back beats with no bubble.
- Downstream latency is 0 cycles. There is no buffering.
- Reset mid-transfer: the in-flight output beat is discarded and `rr_ptr` returns to 0.

## Configuration
- `NOC_ARB_STATS_EN`: when defined, adds output `grant_cnt` [CPU_NB][32].
- Entry `i` increments on every upstream transfer from cpu `i` and saturates at `32'hFFFF_FFFF`. Reset value is 0.
- When not defined, the port and its counters are absent. All other behaviour is identical.

## Test plan
- All 4 cpus hold vld, `noc_out_rdy=1` from reset -> `noc_out_src` sequence 0,1,2,3,0,…; exactly one `cpu_to_noc_rdy` high per cycle; one beat per cycle.
- Only cpu 2 valid with data `0xdeadbeefdeadbef1`, `noc_out_rdy=0` for 5 cycles -> beat held stable with src 2 and no further grants; after rdy rises, data is seen once and `rr_ptr=3`.
- cpus 1 and 3 valid while `rr_ptr=2` -> cpu 3 is granted first, then cpu 1.
- `noc_in_dst=1`, `noc_to_cpu_rdy=4'b0010` -> only `noc_to_cpu_vld[1]` high, `noc_in_rdy=1`; with `noc_to_cpu_rdy[1]=0` -> `noc_in_rdy=0`.
- `noc_in_dst=7`, `noc_in_vld=1` -> `noc_in_rdy=1`, no `noc_to_cpu_vld` asserted, `err_bad_dst=1` from the next cycle until reset.
- With `NOC_ARB_STATS_EN`: 1000 transfers from cpu 0 -> `grant_cnt[0]=1000`, others 0; assert `rst_n` low mid-stream -> all counts 0 and `noc_out_vld=0` immediately.

Source files
------------

// File: rtl/noc_arbiter.sv
// Round-robin cpu->noc ingress arbiter with a one-entry output register, and a zero-latency noc->cpu return router.
// Optional per-cpu grant counters are enabled by defining NOC_ARB_STATS_EN.
module noc_arbiter #(
    parameter int   CPU_NB = 4,
    parameter int   DATA_W = 64,
    localparam int  SRC_W  = $clog2(CPU_NB)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [CPU_NB-1:0]              cpu_to_noc_vld,
    output logic [CPU_NB-1:0]              cpu_to_noc_rdy,
    input  logic [CPU_NB-1:0][DATA_W-1:0]  cpu_to_noc_data,
    output logic                           noc_out_vld,
    input  logic                           noc_out_rdy,
    output logic [DATA_W-1:0]              noc_out_data,
    output logic [SRC_W-1:0]               noc_out_src,
    input  logic                           noc_in_vld,
    output logic                           noc_in_rdy,
    input  logic [DATA_W-1:0]              noc_in_data,
    input  logic [31:0]                    noc_in_dst,
    output logic [CPU_NB-1:0]              noc_to_cpu_vld,
    input  logic [CPU_NB-1:0]              noc_to_cpu_rdy,
    output logic [CPU_NB-1:0][DATA_W-1:0]  noc_to_cpu_data,
`ifdef NOC_ARB_STATS_EN
    output logic [CPU_NB-1:0][31:0]        grant_cnt,
`endif
    output logic                           err_bad_dst
);

    logic                r_out_vld;
    logic [DATA_W-1:0]   r_out_data;
    logic [SRC_W-1:0]    r_out_src;
    logic [SRC_W-1:0]    r_rr_ptr;
    logic                r_err;

    logic                w_any;
    logic [SRC_W-1:0]    w_grant;
    logic                w_load_ok;
    logic                w_take;
    logic [SRC_W-1:0]    w_rr_next;
    logic                w_dst_ok;

    // First requester at or after the pointer, wrapping modulo CPU_NB.
    always_comb begin
        int j;
        j       = 0;
        w_any   = 1'b0;
        w_grant = '0;
        for (int k = 0; k < CPU_NB; k++) begin
            j = int'(r_rr_ptr) + k;
            if (j >= CPU_NB) j = j - CPU_NB;
            if (!w_any && cpu_to_noc_vld[j]) begin
                w_any   = 1'b1;
                w_grant = SRC_W'(j);
            end
        end
    end

    assign w_load_ok = !r_out_vld || noc_out_rdy;
    // rst_n gating keeps every cpu un-accepted while reset is held.
    assign w_take    = w_load_ok && w_any && rst_n;
    assign w_rr_next = (w_grant == SRC_W'(CPU_NB - 1)) ? '0 : w_grant + SRC_W'(1);

    always_comb begin
        cpu_to_noc_rdy = '0;
        if (w_take) cpu_to_noc_rdy[w_grant] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_vld  <= 1'b0;
            r_out_data <= '0;
            r_out_src  <= '0;
            r_rr_ptr   <= '0;
        end else if (w_take) begin
            r_out_vld  <= 1'b1;
            r_out_data <= cpu_to_noc_data[w_grant];
            r_out_src  <= w_grant;
            r_rr_ptr   <= w_rr_next;
        end else if (noc_out_rdy) begin
            r_out_vld  <= 1'b0;
        end
    end

    assign noc_out_vld  = r_out_vld;
    assign noc_out_data = r_out_data;
    assign noc_out_src  = r_out_src;

    // Return path: no storage, out-of-range beats are accepted and dropped.
    assign w_dst_ok   = noc_in_dst < 32'(CPU_NB);
    assign noc_in_rdy = w_dst_ok ? noc_to_cpu_rdy[noc_in_dst[SRC_W-1:0]] : 1'b1;

    always_comb begin
        for (int i = 0; i < CPU_NB; i++) begin
            noc_to_cpu_vld[i]  = noc_in_vld && (noc_in_dst == 32'(i));
            noc_to_cpu_data[i] = noc_in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (noc_in_vld && !w_dst_ok) begin
            r_err <= 1'b1;
        end
    end

    assign err_bad_dst = r_err;

`ifdef NOC_ARB_STATS_EN
    logic [CPU_NB-1:0][31:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            for (int i = 0; i < CPU_NB; i++) begin
                if (w_take && (w_grant == SRC_W'(i)) && (r_cnt[i] != 32'hFFFF_FFFF))
                    r_cnt[i] <= r_cnt[i] + 32'd1;
            end
        end
    end

    assign grant_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_noc_arbiter.sv
// Directed self-checking bench for noc_arbiter; counter checks are active when NOC_ARB_STATS_EN is defined.
module tb_noc_arbiter;
    localparam int N  = 4;
    localparam int DW = 64;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [N-1:0]          cpu_to_noc_vld;
    logic [N-1:0]          cpu_to_noc_rdy;
    logic [N-1:0][DW-1:0]  cpu_to_noc_data;
    logic                  noc_out_vld;
    logic                  noc_out_rdy;
    logic [DW-1:0]         noc_out_data;
    logic [1:0]            noc_out_src;
    logic                  noc_in_vld;
    logic                  noc_in_rdy;
    logic [DW-1:0]         noc_in_data;
    logic [31:0]           noc_in_dst;
    logic [N-1:0]          noc_to_cpu_vld;
    logic [N-1:0]          noc_to_cpu_rdy;
    logic [N-1:0][DW-1:0]  noc_to_cpu_data;
    logic                  err_bad_dst;
`ifdef NOC_ARB_STATS_EN
    logic [N-1:0][31:0]    grant_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    noc_arbiter #(.CPU_NB(N), .DATA_W(DW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cpu_to_noc_vld  (cpu_to_noc_vld),
        .cpu_to_noc_rdy  (cpu_to_noc_rdy),
        .cpu_to_noc_data (cpu_to_noc_data),
        .noc_out_vld     (noc_out_vld),
        .noc_out_rdy     (noc_out_rdy),
        .noc_out_data    (noc_out_data),
        .noc_out_src     (noc_out_src),
        .noc_in_vld      (noc_in_vld),
        .noc_in_rdy      (noc_in_rdy),
        .noc_in_data     (noc_in_data),
        .noc_in_dst      (noc_in_dst),
        .noc_to_cpu_vld  (noc_to_cpu_vld),
        .noc_to_cpu_rdy  (noc_to_cpu_rdy),
        .noc_to_cpu_data (noc_to_cpu_data),
`ifdef NOC_ARB_STATS_EN
        .grant_cnt       (grant_cnt),
`endif
        .err_bad_dst     (err_bad_dst)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] e_rdy;
        rst_n          = 1'b0;
        cpu_to_noc_vld = 4'hF;
        noc_out_rdy    = 1'b1;
        noc_in_vld     = 1'b0;
        noc_in_data    = 64'h0123_4567_89AB_CDEF;
        noc_in_dst     = 32'd0;
        noc_to_cpu_rdy = 4'h0;
        for (int k = 0; k < N; k++) cpu_to_noc_data[k] = 64'hA5A5_0000_0000_0000 | 64'(k);

        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_vld", 64'(noc_out_vld), 64'd0);
        chk("rst_out_data", noc_out_data, 64'd0);
        chk("rst_out_src", 64'(noc_out_src), 64'd0);
        chk("rst_cpu_rdy", 64'(cpu_to_noc_rdy), 64'd0);
        chk("rst_err", 64'(err_bad_dst), 64'd0);

        // all four requesting, sink always ready
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) begin
            e_rdy = 4'b0001 << (i % 4);
            chk("rr_rdy", 64'(cpu_to_noc_rdy), 64'(e_rdy));
            if (i > 0) begin
                chk("rr_vld", 64'(noc_out_vld), 64'd1);
                chk("rr_src", 64'(noc_out_src), 64'((i - 1) % 4));
                chk("rr_data", noc_out_data, 64'hA5A5_0000_0000_0000 | 64'((i - 1) % 4));
            end
            step();
        end
        cpu_to_noc_vld = 4'b0000;
        #1;
        chk("drain_src", 64'(noc_out_src), 64'd3);
        chk("drain_rdy", 64'(cpu_to_noc_rdy), 64'd0);
        step();
        chk("drain_vld", 64'(noc_out_vld), 64'd0);

        // cpu 2 alone, sink stalled for five cycles
        cpu_to_noc_data[2] = 64'hdead_beef_dead_bef1;
        cpu_to_noc_vld     = 4'b0100;
        noc_out_rdy        = 1'b0;
        #1;
        chk("c2_grant", 64'(cpu_to_noc_rdy), 64'b0100);
        step();
        for (int i = 0; i < 5; i++) begin
            chk("stall_vld", 64'(noc_out_vld), 64'd1);
            chk("stall_src", 64'(noc_out_src), 64'd2);
            chk("stall_data", noc_out_data, 64'hdead_beef_dead_bef1);
            chk("stall_rdy", 64'(cpu_to_noc_rdy), 64'd0);
            step();
        end
        cpu_to_noc_vld = 4'b0000;
        noc_out_rdy    = 1'b1;
        #1;
        chk("c2_release_rdy", 64'(cpu_to_noc_rdy), 64'd0);
        step();
        chk("c2_once", 64'(noc_out_vld), 64'd0);

        // pointer now 3: cpu 3 wins over cpu 0
        cpu_to_noc_vld = 4'b1001;
        #1;
        chk("ptr3_grant", 64'(cpu_to_noc_rdy), 64'b1000);
        step();
        cpu_to_noc_vld = 4'b0010;
        #1;
        chk("ptr0_src", 64'(noc_out_src), 64'd3);
        chk("c1_grant", 64'(cpu_to_noc_rdy), 64'b0010);
        step();
        // pointer now 2: cpus 1 and 3 -> 3 first, then 1
        cpu_to_noc_vld = 4'b1010;
        #1;
        chk("c1_src", 64'(noc_out_src), 64'd1);
        chk("ptr2_grant3", 64'(cpu_to_noc_rdy), 64'b1000);
        step();
        chk("ptr2_src3", 64'(noc_out_src), 64'd3);
        chk("ptr0_grant1", 64'(cpu_to_noc_rdy), 64'b0010);
        step();
        cpu_to_noc_vld = 4'b0000;
        #1;
        chk("ptr_src1", 64'(noc_out_src), 64'd1);
        step();
        chk("ptr_idle", 64'(noc_out_vld), 64'd0);

        // return path
        noc_in_vld     = 1'b1;
        noc_in_dst     = 32'd1;
        noc_to_cpu_rdy = 4'b0010;
        #1;
        chk("dn_vld", 64'(noc_to_cpu_vld), 64'b0010);
        chk("dn_rdy", 64'(noc_in_rdy), 64'd1);
        chk("dn_bcast", noc_to_cpu_data[3], 64'h0123_4567_89AB_CDEF);
        noc_to_cpu_rdy = 4'b1101;
        #1;
        chk("dn_stall", 64'(noc_in_rdy), 64'd0);
        chk("dn_noerr", 64'(err_bad_dst), 64'd0);
        noc_in_dst = 32'd7;
        #1;
        chk("bad_rdy", 64'(noc_in_rdy), 64'd1);
        chk("bad_vld", 64'(noc_to_cpu_vld), 64'd0);
        chk("bad_err_pre", 64'(err_bad_dst), 64'd0);
        step();
        chk("bad_err_set", 64'(err_bad_dst), 64'd1);
        noc_in_vld = 1'b0;
        noc_in_dst = 32'd0;
        step();
        step();
        chk("bad_err_sticky", 64'(err_bad_dst), 64'd1);

        // reset with a stalled beat in flight
        cpu_to_noc_vld = 4'b0100;
        noc_out_rdy    = 1'b0;
        step();
        chk("mid_loaded", 64'(noc_out_vld), 64'd1);
        cpu_to_noc_vld = 4'b1111;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", 64'(noc_out_vld), 64'd0);
        chk("mid_rst_src", 64'(noc_out_src), 64'd0);
        chk("mid_rst_err", 64'(err_bad_dst), 64'd0);
        chk("mid_rst_rdy", 64'(cpu_to_noc_rdy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid_ptr0", 64'(cpu_to_noc_rdy), 64'b0001);

`ifdef NOC_ARB_STATS_EN
        cpu_to_noc_vld = 4'b0000;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n          = 1'b1;
        cpu_to_noc_vld = 4'b0001;
        noc_out_rdy    = 1'b1;
        #1;
        for (int i = 0; i < 1000; i++) step();
        chk("cnt0", 64'(grant_cnt[0]), 64'd1000);
        chk("cnt1", 64'(grant_cnt[1]), 64'd0);
        chk("cnt2", 64'(grant_cnt[2]), 64'd0);
        chk("cnt3", 64'(grant_cnt[3]), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("cnt_rst0", 64'(grant_cnt[0]), 64'd0);
        chk("cnt_rst_vld", 64'(noc_out_vld), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
